fix_checksum_verify: RTL and testbench
======================================

Name: fix_checksum_verify

Overview:
Streaming FIX checksum verifier for the parser datapath. It accepts a message as LANES bytes per beat and accumulates the modulo-256 byte sum. It extracts and validates the trailing "10=NNN<SOH>" field, then reports calculated and received checksums through a valid/ready result port. It generalises the single-byte checksum block to multi-lane input, adds backpressure and format checking, and parses the trailer internally.

Parameters:
LANES, 4, bytes per input beat (1..8); lane 0 carries the earliest byte.
LEN_W, 16, width of the message byte counter; saturates at all-ones.

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
s_valid  in  1  input beat valid
s_ready  out  1  block can accept a beat
s_data  in  8*LANES  message bytes; lane i = s_data[8*i+7:8*i]
s_keep  in  LANES  lane-valid mask; must be contiguous from lane 0
s_sop  in  1  first beat of a message
s_eop  in  1  last beat of a message
res_valid  out  1  result available
res_ready  in  1  result consumed
res_ok  out  1  format good and calc == rcv
res_fmt_err  out  1  trailer malformed, message too short, or keep non-contiguous
res_calc  out  8  computed checksum
res_rcv  out  8  parsed checksum (0 when res_fmt_err)
res_len  out  LEN_W  total bytes in message, trailer included

Behaviour:
- Reset (rst=1 at clk edge): state IDLE; s_ready=1; res_valid, res_ok, res_fmt_err=0; res_calc, res_rcv, res_len=0. Sum, window and counter cleared. Applies mid-message and mid-result: the partial message is discarded and any pending result is dropped.
- Beat accepted when s_valid && s_ready.
- FSM states:
  - IDLE: s_ready=1. A beat with s_sop -> ACCUM (or CALC if s_eop is also set). Beats without s_sop are accepted and discarded.
  - ACCUM: s_ready=1. Each beat adds its kept bytes to the 8-bit wrapping sum, adds popcount(s_keep) to the length, and shifts the kept bytes into a 7-byte history window (oldest byte out). A beat with s_eop -> CALC. A beat with s_sop restarts accumulation from that beat; the old message is dropped with no result.
  - CALC: s_ready=0, one cycle. calc = sum - (sum of 7 window bytes), mod 256. Trailer check runs here. -> REPORT.
  - REPORT: res_valid=1 and s_ready=0. Outputs hold stable until res_ready. On handshake -> IDLE, res_valid=0 next cycle.
- Latency: res_valid rises 2 cycles after the s_eop beat is accepted. Throughput: at most one message per (beats + 2 + result wait) cycles.
- Trailer check: window must equal '1','0','=',D2,D1,D0,0x01 with each D in '0'..'9'. rcv = 100*D2 + 10*D1 + D0, computed in 10 bits; rcv > 255 is a format error.
- Length check: length < 8 (no body byte) is a format error.
- Keep check: s_keep non-contiguous on any beat sets a sticky format error for that message; bytes are still summed per the mask.
- res_ok = !res_fmt_err && (res_calc == res_rcv).
- Byte counter saturates at 2^LEN_W-1. Checksum arithmetic always wraps mod 256.
- s_keep=0 beats are legal, contribute nothing, and still honour s_sop/s_eop.

Optional Feature:
FIX_CKSUM_STATS_EN: when defined, adds outputs stat_good[31:0], stat_bad[31:0] and stat_abort[15:0]. These are saturating counters, incremented at the result handshake (ok / not ok) or at a mid-message s_sop restart, and cleared by rst. When not defined, the ports and logic are absent and the block behaves identically otherwise.

Decomposition:
- Package fix_cksum_pkg:
  - state enum {IDLE, ACCUM, CALC, REPORT};
  - constants ASCII_SOH=8'h01, ASCII_EQ=8'h3D, ASCII_0=8'h30, TRAILER_LEN=7, MIN_MSG_LEN=8;
  - packed struct cksum_res_t {ok, fmt_err, calc, rcv}.
- One sub-module, fix_trailer_parse: combinational. Takes the 7-byte window and returns rcv[7:0] and fmt_err.

Test Plan:
- LANES=4: "AB<SOH>10=132<SOH>" (10 bytes, 3 beats, last keep=4'b0011) -> res_calc=0x84, res_rcv=132, res_ok=1, res_len=10, res_valid 2 cycles after eop.
- Same message with "10=133" -> res_ok=0, res_fmt_err=0, res_calc=132, res_rcv=133.
- 256 bytes of 0xFF then "10=000<SOH>" -> wrap: res_calc=0, res_ok=1, res_len=263.
- Trailers "10=1A2<SOH>", "10=300<SOH>", and a 7-byte message "10=000<SOH>" -> res_fmt_err=1, res_ok=0, res_rcv=0 for each.
- Hold res_ready=0 for 5 cycles -> outputs stable, s_ready=0, input stalled. Then a new s_sop mid-message restarts; only the second message reports (stat_abort=1 with FIX_CKSUM_STATS_EN).
- rst asserted in ACCUM and again in REPORT -> next cycle res_valid=0, s_ready=1, and the next message's result is correct and unaffected.

Source files
------------

// File: rtl/fix_cksum_pkg.sv
// Shared types and constants for the FIX checksum verifier.
// No logic; used by fix_checksum_verify and fix_trailer_parse.
package fix_cksum_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    CALC,
    REPORT
  } state_t;

  localparam logic [7:0] ASCII_SOH   = 8'h01;
  localparam logic [7:0] ASCII_EQ    = 8'h3D;
  localparam logic [7:0] ASCII_0     = 8'h30;
  localparam int         TRAILER_LEN = 7;
  localparam int         MIN_MSG_LEN = 8;

  typedef struct packed {
    logic       ok;
    logic       fmt_err;
    logic [7:0] calc;
    logic [7:0] rcv;
  } cksum_res_t;

  function automatic logic is_digit(input logic [7:0] c);
    return (c >= ASCII_0) && (c <= (ASCII_0 + 8'd9));
  endfunction

  function automatic logic [3:0] digit_val(input logic [7:0] c);
    logic [7:0] d;
    d = c - ASCII_0;
    return d[3:0];
  endfunction

endpackage

// File: rtl/fix_trailer_parse.sv
// Combinational check of the 7-byte "10=NNN<SOH>" trailer window (byte 0 oldest).
// Returns the parsed checksum, or 0 with o_fmt_err when the window is malformed or > 255.
module fix_trailer_parse
  import fix_cksum_pkg::*;
(
  input  logic [TRAILER_LEN-1:0][7:0] i_win,
  output logic [7:0]                  o_rcv,
  output logic                        o_fmt_err
);

  logic       w_shape_ok;
  logic [9:0] w_rcv10;

  always_comb begin
    w_shape_ok = (i_win[0] == (ASCII_0 + 8'd1)) &&
                 (i_win[1] == ASCII_0) &&
                 (i_win[2] == ASCII_EQ) &&
                 is_digit(i_win[3]) &&
                 is_digit(i_win[4]) &&
                 is_digit(i_win[5]) &&
                 (i_win[6] == ASCII_SOH);
    // Three decimal digits fit in 10 bits; only meaningful when the shape is good.
    w_rcv10 = 10'(digit_val(i_win[3])) * 10'd100 +
              10'(digit_val(i_win[4])) * 10'd10 +
              10'(digit_val(i_win[5]));
    o_fmt_err = !w_shape_ok || (w_rcv10 > 10'd255);
    o_rcv     = o_fmt_err ? 8'h00 : w_rcv10[7:0];
  end

endmodule

// File: rtl/fix_checksum_verify.sv
// Streaming FIX checksum verifier: result 2 cycles after the eop beat; s_ready low from eop until the result handshake.
// Optional saturating stats ports under FIX_CKSUM_STATS_EN.
module fix_checksum_verify
  import fix_cksum_pkg::*;
#(
  parameter int LANES = 4,
  parameter int LEN_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               s_valid,
  output logic               s_ready,
  input  logic [8*LANES-1:0] s_data,
  input  logic [LANES-1:0]   s_keep,
  input  logic               s_sop,
  input  logic               s_eop,
  output logic               res_valid,
  input  logic               res_ready,
  output logic               res_ok,
  output logic               res_fmt_err,
  output logic [7:0]         res_calc,
  output logic [7:0]         res_rcv,
  output logic [LEN_W-1:0]   res_len
`ifdef FIX_CKSUM_STATS_EN
  ,
  output logic [31:0]        stat_good,
  output logic [31:0]        stat_bad,
  output logic [15:0]        stat_abort
`endif
);

  state_t                       r_state;
  logic                         r_s_ready;
  logic                         r_res_valid;
  cksum_res_t                   r_res;
  logic [LEN_W-1:0]             r_res_len;
  logic [7:0]                   r_sum;
  logic [TRAILER_LEN-1:0][7:0]  r_win;
  logic [LEN_W-1:0]             r_len;
  logic                         r_gap;

  logic [7:0]                   w_sum_next;
  logic [TRAILER_LEN-1:0][7:0]  w_win_next;
  logic [LEN_W-1:0]             w_kcnt;
  logic [LEN_W-1:0]             w_len_base;
  logic [LEN_W:0]               w_len_wide;
  logic [LEN_W-1:0]             w_len_next;
  logic [LANES-1:0]             w_keep_inc;
  logic                         w_gap_next;
  logic [7:0]                   w_win_sum;
  logic [7:0]                   w_calc;
  logic [7:0]                   w_tp_rcv;
  logic                         w_tp_fmt;
  logic                         w_fmt_err;

  // Next accumulation state for the current beat; a sop beat starts from empty.
  always_comb begin
    w_sum_next = s_sop ? 8'h00 : r_sum;
    w_win_next = s_sop ? '0 : r_win;
    w_kcnt     = '0;
    for (int i = 0; i < LANES; i++) begin
      if (s_keep[i]) begin
        w_sum_next = w_sum_next + s_data[8*i +: 8];
        for (int j = 0; j < TRAILER_LEN - 1; j++) begin
          w_win_next[j] = w_win_next[j+1];
        end
        w_win_next[TRAILER_LEN-1] = s_data[8*i +: 8];
        w_kcnt = w_kcnt + LEN_W'(1);
      end
    end
    w_len_base = s_sop ? '0 : r_len;
    w_len_wide = {1'b0, w_len_base} + {1'b0, w_kcnt};
    w_len_next = w_len_wide[LEN_W] ? '1 : w_len_wide[LEN_W-1:0];
    w_keep_inc = s_keep + LANES'(1);
    w_gap_next = (s_sop ? 1'b0 : r_gap) | ((s_keep & w_keep_inc) != '0);
  end

  // The window holds the trailer, so removing it from the running sum leaves the body sum.
  always_comb begin
    w_win_sum = '0;
    for (int j = 0; j < TRAILER_LEN; j++) begin
      w_win_sum = w_win_sum + r_win[j];
    end
    w_calc    = r_sum - w_win_sum;
    w_fmt_err = w_tp_fmt || r_gap || (r_len < LEN_W'(MIN_MSG_LEN));
  end

  fix_trailer_parse u_trailer_parse (
    .i_win     (r_win),
    .o_rcv     (w_tp_rcv),
    .o_fmt_err (w_tp_fmt)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_s_ready   <= 1'b1;
      r_res_valid <= 1'b0;
      r_res       <= '0;
      r_res_len   <= '0;
      r_sum       <= '0;
      r_win       <= '0;
      r_len       <= '0;
      r_gap       <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (s_valid && s_sop) begin
            r_sum     <= w_sum_next;
            r_win     <= w_win_next;
            r_len     <= w_len_next;
            r_gap     <= w_gap_next;
            r_state   <= s_eop ? CALC : ACCUM;
            r_s_ready <= !s_eop;
          end
        end
        ACCUM: begin
          if (s_valid) begin
            r_sum <= w_sum_next;
            r_win <= w_win_next;
            r_len <= w_len_next;
            r_gap <= w_gap_next;
            if (s_eop) begin
              r_state   <= CALC;
              r_s_ready <= 1'b0;
            end
          end
        end
        CALC: begin
          r_res.calc    <= w_calc;
          r_res.rcv     <= w_fmt_err ? 8'h00 : w_tp_rcv;
          r_res.fmt_err <= w_fmt_err;
          r_res.ok      <= !w_fmt_err && (w_calc == w_tp_rcv);
          r_res_len     <= r_len;
          r_res_valid   <= 1'b1;
          r_state       <= REPORT;
        end
        REPORT: begin
          if (res_ready) begin
            r_res_valid <= 1'b0;
            r_s_ready   <= 1'b1;
            r_state     <= IDLE;
          end
        end
        default: begin
          r_state   <= IDLE;
          r_s_ready <= 1'b1;
        end
      endcase
    end
  end

`ifdef FIX_CKSUM_STATS_EN
  logic [31:0] r_stat_good;
  logic [31:0] r_stat_bad;
  logic [15:0] r_stat_abort;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_stat_good  <= '0;
      r_stat_bad   <= '0;
      r_stat_abort <= '0;
    end else begin
      if (r_res_valid && res_ready) begin
        if (r_res.ok) begin
          if (r_stat_good != '1) r_stat_good <= r_stat_good + 32'd1;
        end else begin
          if (r_stat_bad != '1) r_stat_bad <= r_stat_bad + 32'd1;
        end
      end
      if ((r_state == ACCUM) && s_valid && s_sop && (r_stat_abort != '1)) begin
        r_stat_abort <= r_stat_abort + 16'd1;
      end
    end
  end

  assign stat_good  = r_stat_good;
  assign stat_bad   = r_stat_bad;
  assign stat_abort = r_stat_abort;
`endif

  assign s_ready     = r_s_ready;
  assign res_valid   = r_res_valid;
  assign res_ok      = r_res.ok;
  assign res_fmt_err = r_res.fmt_err;
  assign res_calc    = r_res.calc;
  assign res_rcv     = r_res.rcv;
  assign res_len     = r_res_len;

endmodule

// File: tb/tb_fix_checksum_verify.sv
// Bench for fix_checksum_verify: vector table, hand-written corner sequences, random messages vs a byte-level model.
module tb_fix_checksum_verify;
  localparam int LANES = 4;
  localparam int LEN_W = 16;

  logic               clk = 1'b0;
  logic               rst;
  logic               s_valid;
  logic               s_ready;
  logic [8*LANES-1:0] s_data;
  logic [LANES-1:0]   s_keep;
  logic               s_sop;
  logic               s_eop;
  logic               res_valid;
  logic               res_ready;
  logic               res_ok;
  logic               res_fmt_err;
  logic [7:0]         res_calc;
  logic [7:0]         res_rcv;
  logic [LEN_W-1:0]   res_len;
`ifdef FIX_CKSUM_STATS_EN
  logic [31:0]        stat_good;
  logic [31:0]        stat_bad;
  logic [15:0]        stat_abort;
  int                 exp_good = 0;
  int                 exp_bad = 0;
  int                 exp_abort = 0;
`endif

  always #5 clk = ~clk;

  fix_checksum_verify #(.LANES(LANES), .LEN_W(LEN_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .s_valid     (s_valid),
    .s_ready     (s_ready),
    .s_data      (s_data),
    .s_keep      (s_keep),
    .s_sop       (s_sop),
    .s_eop       (s_eop),
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .res_ok      (res_ok),
    .res_fmt_err (res_fmt_err),
    .res_calc    (res_calc),
    .res_rcv     (res_rcv),
    .res_len     (res_len)
`ifdef FIX_CKSUM_STATS_EN
    ,
    .stat_good   (stat_good),
    .stat_bad    (stat_bad),
    .stat_abort  (stat_abort)
`endif
  );

  int n_pass = 0;
  int n_chk  = 0;

  typedef struct {
    string      body;
    bit         soh;
    string      trl;
    logic [7:0] tend;
    bit         ok;
    bit         fmt;
    int         calc;
    int         rcv;
    int         len;
  } vec_t;

  vec_t       tv[11];
  logic [7:0] mq[$];

  task automatic check(input string name, input longint act, input longint exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic add_str(input string s);
    for (int i = 0; i < s.len(); i++) mq.push_back(s[i]);
  endtask

  task automatic build(input vec_t v);
    mq.delete();
    add_str(v.body);
    if (v.soh) mq.push_back(8'h01);
    add_str(v.trl);
    mq.push_back(v.tend);
  endtask

  // Byte-level reference: body = everything before the last 7 bytes, trailer = last 7.
  task automatic model(input bit gap, output bit eok, output bit efmt,
                       output int ecalc, output int ercv, output int elen);
    int n, sum, v;
    bit bad;
    n = mq.size();
    sum = 0;
    for (int i = 0; i < n - 7; i++) sum += mq[i];
    ecalc = sum % 256;
    bad = gap || (n < 8);
    v = 0;
    if (n >= 7) begin
      if (mq[n-7] != "1" || mq[n-6] != "0" || mq[n-5] != "=" || mq[n-1] != 8'h01) bad = 1;
      for (int k = 0; k < 3; k++) begin
        if (mq[n-4+k] < "0" || mq[n-4+k] > "9") bad = 1;
        else v = v * 10 + (mq[n-4+k] - "0");
      end
      if (v > 255) bad = 1;
    end else begin
      bad = 1;
    end
    efmt = bad;
    ercv = bad ? 0 : v;
    eok  = !bad && (ecalc == ercv);
    elen = (n > 65535) ? 65535 : n;
  endtask

  task automatic put_beat(input logic [8*LANES-1:0] d, input logic [LANES-1:0] k,
                          input logic sop, input logic eop);
    int n;
    @(negedge clk);
    s_valid = 1'b1; s_data = d; s_keep = k; s_sop = sop; s_eop = eop;
    n = 0;
    while (!s_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!s_ready) check("beat_accept_timeout", 0, 1);
    @(posedge clk);
  endtask

  // Sends mq; shaped=1 randomises beat fill, idle gaps and trailing empty eop beats.
  task automatic send_msg(input bit shaped, input bit with_eop);
    int idx, nb, k;
    bit first, last;
    logic [8*LANES-1:0] d;
    logic [LANES-1:0]   kk;
    idx = 0; nb = mq.size(); first = 1;
    while (1) begin
      k = shaped ? $urandom_range(0, LANES) : LANES;
      d = $urandom;
      kk = '0;
      for (int i = 0; i < LANES; i++) begin
        if (i < k && idx < nb) begin
          d[8*i +: 8] = mq[idx];
          kk[i] = 1'b1;
          idx++;
        end
      end
      last = (idx >= nb);
      if (shaped && $urandom_range(0, 3) == 0) begin
        @(negedge clk);
        s_valid = 1'b0;
      end
      if (shaped && last && $urandom_range(0, 3) == 0) begin
        put_beat(d, kk, first, 1'b0);
        put_beat($urandom, '0, 1'b0, with_eop);
        break;
      end
      put_beat(d, kk, first, last && with_eop);
      first = 0;
      if (last) break;
    end
  endtask

  task automatic wait_valid(input string tag);
    int lat;
    @(negedge clk);
    s_valid = 1'b0;
    lat = 1;
    while (!res_valid && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    check({tag, " latency"}, lat, 2);
  endtask

  task automatic check_res(input string tag, input bit eok, input bit efmt,
                           input int ecalc, input int ercv, input int elen);
    check({tag, " res_ok"}, res_ok, eok);
    check({tag, " res_fmt_err"}, res_fmt_err, efmt);
    check({tag, " res_calc"}, res_calc, ecalc);
    check({tag, " res_rcv"}, res_rcv, ercv);
    check({tag, " res_len"}, res_len, elen);
  endtask

  task automatic handshake(input string tag, input int hold, input bit eok);
    repeat (hold) @(negedge clk);
    res_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    res_ready = 1'b0;
    check({tag, " res_valid drop"}, res_valid, 0);
`ifdef FIX_CKSUM_STATS_EN
    if (eok) exp_good++;
    else exp_bad++;
`endif
  endtask

  task automatic collect(input string tag, input bit eok, input bit efmt,
                         input int ecalc, input int ercv, input int elen, input int hold);
    wait_valid(tag);
    check_res(tag, eok, efmt, ecalc, ercv, elen);
    handshake(tag, hold, eok);
  endtask

  task automatic pulse_rst();
    @(negedge clk);
    s_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
`ifdef FIX_CKSUM_STATS_EN
    exp_good = 0; exp_bad = 0; exp_abort = 0;
`endif
  endtask

  initial begin
    bit eok, efmt;
    int ecalc, ercv, elen, val;
    string tag;

    tv[0]  = '{"AB", 1, "10=132", 8'h01, 1, 0, 132, 132, 10};
    tv[1]  = '{"AB", 1, "10=133", 8'h01, 0, 0, 132, 133, 10};
    tv[2]  = '{"AB", 1, "10=1A2", 8'h01, 0, 1, 132, 0, 10};
    tv[3]  = '{"AB", 1, "10=300", 8'h01, 0, 1, 132, 0, 10};
    tv[4]  = '{"",   0, "10=000", 8'h01, 0, 1, 0,   0, 7};
    tv[5]  = '{"X",  0, "10=088", 8'h01, 1, 0, 88,  88, 8};
    tv[6]  = '{"AB", 1, "10=132", 8'h7C, 0, 1, 132, 0, 10};
    tv[7]  = '{"AB", 1, "11=132", 8'h01, 0, 1, 132, 0, 10};
    tv[8]  = '{"~~", 0, "10=252", 8'h01, 1, 0, 252, 252, 9};
    tv[9]  = '{"~~", 0, "10=255", 8'h01, 0, 0, 252, 255, 9};
    tv[10] = '{"~~", 0, "10=256", 8'h01, 0, 1, 252, 0, 9};

    rst = 1'b1; s_valid = 1'b0; s_data = '0; s_keep = '0; s_sop = 1'b0; s_eop = 1'b0;
    res_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("reset s_ready", s_ready, 1);
    check("reset res_valid", res_valid, 0);
    check_res("reset", 0, 0, 0, 0, 0);
    rst = 1'b0;

    for (int t = 0; t < 11; t++) begin
      build(tv[t]);
      send_msg(1'b0, 1'b1);
      tag = $sformatf("vec%0d", t);
      collect(tag, tv[t].ok, tv[t].fmt, tv[t].calc, tv[t].rcv, tv[t].len, 0);
    end

    // Non-contiguous keep on the first beat: bytes still counted, message flagged.
    put_beat(32'h01_55_42_41, 4'b1011, 1'b1, 1'b0);
    put_beat(32'h31_3D_30_31, 4'b1111, 1'b0, 1'b0);
    put_beat(32'h00_01_32_33, 4'b0111, 1'b0, 1'b1);
    collect("keep_gap", 0, 1, 132, 0, 10, 0);

    mq.delete();
    repeat (256) mq.push_back(8'hFF);
    add_str("10=000"); mq.push_back(8'h01);
    send_msg(1'b0, 1'b1);
    collect("wrap", 1, 0, 0, 0, 263, 0);

    // Result held while the input side offers a beat that must stall.
    build(tv[0]);
    send_msg(1'b0, 1'b1);
    wait_valid("stall");
    for (int c = 0; c < 5; c++) begin
      s_valid = 1'b1; s_sop = 1'b0; s_eop = 1'b0; s_keep = '1;
      check("stall s_ready", s_ready, 0);
      check("stall res_valid", res_valid, 1);
      check("stall res_calc", res_calc, 132);
      check("stall res_len", res_len, 10);
      @(negedge clk);
    end
    s_valid = 1'b0;
    handshake("stall", 0, 1);

    mq.delete();
    add_str("ZZZZZZ");
    send_msg(1'b0, 1'b0);
    build(tv[5]);
    send_msg(1'b0, 1'b1);
`ifdef FIX_CKSUM_STATS_EN
    exp_abort++;
    check("stat_abort after restart", stat_abort, exp_abort);
`endif
    collect("restart", 1, 0, 88, 88, 8, 2);

    build(tv[1]);
    send_msg(1'b0, 1'b0);
    pulse_rst();
    check("rst_accum s_ready", s_ready, 1);
    check("rst_accum res_valid", res_valid, 0);
    build(tv[0]);
    send_msg(1'b0, 1'b1);
    collect("after_rst_accum", 1, 0, 132, 132, 10, 0);

    build(tv[1]);
    send_msg(1'b0, 1'b1);
    wait_valid("rst_report");
    pulse_rst();
    check("rst_report s_ready", s_ready, 1);
    check("rst_report res_valid", res_valid, 0);
    check_res("rst_report", 0, 0, 0, 0, 0);
    build(tv[5]);
    send_msg(1'b0, 1'b1);
    collect("after_rst_report", 1, 0, 88, 88, 8, 0);

    for (int r = 0; r < 40; r++) begin
      mq.delete();
      val = 0;
      for (int b = $urandom_range(0, 12); b > 0; b--) begin
        mq.push_back(8'($urandom));
        val += mq[mq.size()-1];
      end
      val = val % 256;
      case ($urandom_range(0, 9))
        6:       val = $urandom_range(0, 999);
        7, 8:    val = (val + $urandom_range(1, 255)) % 256;
        default: ;
      endcase
      add_str("10=");
      mq.push_back(8'h30 + 8'(val / 100));
      mq.push_back(8'h30 + 8'((val / 10) % 10));
      mq.push_back(8'h30 + 8'(val % 10));
      mq.push_back(8'h01);
      if ($urandom_range(0, 9) == 0) mq[mq.size() - $urandom_range(1, 7)] = 8'($urandom);
      model(1'b0, eok, efmt, ecalc, ercv, elen);
      send_msg(1'b1, 1'b1);
      tag = $sformatf("rnd%0d", r);
      collect(tag, eok, efmt, ecalc, ercv, elen, $urandom_range(0, 3));
    end

    mq.delete();
    repeat (65533) mq.push_back(8'h00);
    add_str("10=000"); mq.push_back(8'h01);
    model(1'b0, eok, efmt, ecalc, ercv, elen);
    send_msg(1'b0, 1'b1);
    collect("len_sat", eok, efmt, ecalc, ercv, elen, 0);
    check("len_sat value", res_len, 65535);

`ifdef FIX_CKSUM_STATS_EN
    check("stat_good", stat_good, exp_good);
    check("stat_bad", stat_bad, exp_bad);
    check("stat_abort", stat_abort, exp_abort);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
